// File: rtl/wreg_loader.sv
// Write-side loader for the FC weight register. It collects one output row per valid/ready beat
// into a shadow buffer and then pulses the register enable once. Optional macro: WLOAD_CHECKSUM_EN.
module wreg_loader #(
  parameter int DIM_OUT = 16,
  parameter int DIM_IN  = 110,
  parameter int INWD    = 8,
  parameter int CKWD    = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [DIM_IN*INWD-1:0]                     s_data,
  input  logic [CKWD-1:0]                            exp_cksum,
  output logic [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0]   wr_data,
  output logic                                       wr_en,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       err
);

  localparam int CW = (DIM_OUT > 1) ? $clog2(DIM_OUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIM_OUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                                   state_q;
  logic [CW-1:0]                            cnt_q;
  logic [DIM_OUT-1:0][DIM_IN-1:0][INWD-1:0] buf_q;
  logic                                     s_ready_q;
  logic                                     wr_en_q;
  logic                                     done_q;
  logic                                     busy_q;

  logic accept;
  logic last_beat;
  logic commit_ok;

  // s_ready_q is high exactly while in LOAD, so the handshake needs no state decode.
  assign accept    = s_valid & s_ready_q;
  assign last_beat = accept && (cnt_q == LAST);

`ifdef WLOAD_CHECKSUM_EN
  function automatic logic [CKWD-1:0] row_sum(input logic [DIM_IN*INWD-1:0] row);
    logic [CKWD-1:0] s;
    s = '0;
    for (int j = 0; j < DIM_IN; j++) begin
      s = s + CKWD'(row[j*INWD +: INWD]);
    end
    return s;
  endfunction

  logic [CKWD-1:0] acc_q;
  logic [CKWD-1:0] acc_d;
  logic [CKWD-1:0] exp_q;
  logic            err_q;

  // The final beat is included in the comparison so the verdict is ready for the COMMIT cycle.
  assign acc_d     = acc_q + row_sum(s_data);
  assign commit_ok = (acc_d == exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      exp_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      acc_q <= '0;
      exp_q <= exp_cksum;
      err_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      if (last_beat && !commit_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  logic unused_cksum;

  assign unused_cksum = ^exp_cksum;
  assign commit_ok    = 1'b1;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      buf_q     <= '0;
      s_ready_q <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            buf_q[cnt_q] <= s_data;
            if (last_beat) begin
              state_q   <= COMMIT;
              s_ready_q <= 1'b0;
              wr_en_q   <= commit_ok;
              done_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign wr_data = buf_q;
  assign wr_en   = wr_en_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
